// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: line address, line data and line-offset width.
package lc3b_types;

   localparam int LINE_OFFSET_W = 4;

   typedef logic [15:0]  lc3b_pmem_addr;
   typedef logic [127:0] lc3b_pmem_line;

   function automatic logic same_line(input lc3b_pmem_addr a, input lc3b_pmem_addr b);
      return a[15:LINE_OFFSET_W] == b[15:LINE_OFFSET_W];
   endfunction

endpackage

// File: rtl/l2_wb_entry.sv
// Single write-buffer entry: holds one dirty line and reports a line-address match.
module l2_wb_entry
   import lc3b_types::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic         clr,
   input  logic [15:0]  wr_addr,
   input  logic [127:0] wr_data,
   input  logic [15:0]  cmp_addr,
   output logic [15:0]  addr,
   output logic [127:0] data,
   output logic         valid,
   output logic         match
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr  <= '0;
         data  <= '0;
         valid <= 1'b0;
      end else if (wr_en) begin
         addr  <= wr_addr;
         data  <= wr_data;
         valid <= 1'b1;
      end else if (clr) begin
         valid <= 1'b0;
      end
   end

   // Offset bits are ignored: a hit is any address within the buffered line.
   assign match = valid && same_line(cmp_addr, addr);

endmodule

// File: rtl/l2_write_buffer.sv
// One-entry write buffer between L2 and main memory, with read forwarding,
// read bypass of the pending drain, write coalescing and background drain.
module l2_write_buffer
   import lc3b_types::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [15:0]  mem_address,
   input  logic [127:0] mem_wdata,
   output logic         mem_resp,
   output logic [127:0] mem_rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic         pmem_resp,
   input  logic [127:0] pmem_rdata,
   output logic         buf_valid,
   output logic [15:0]  fwd_count
);

   typedef enum logic [1:0] {IDLE, RESP, READ_MEM, DRAIN} state_t;

   state_t        state;
   lc3b_pmem_addr buf_addr;
   lc3b_pmem_line buf_data;
   logic          match;
   logic          entry_wr;
   logic          entry_clr;

   // Reads win over writes; a write lands only on an empty buffer or its own line.
   assign entry_wr  = (state == IDLE) && !mem_read && mem_write && (!buf_valid || match);
   assign entry_clr = (state == DRAIN) && pmem_resp;

   l2_wb_entry u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (entry_wr),
      .clr      (entry_clr),
      .wr_addr  (mem_address),
      .wr_data  (mem_wdata),
      .cmp_addr (mem_address),
      .addr     (buf_addr),
      .data     (buf_data),
      .valid    (buf_valid),
      .match    (match)
   );

   assign pmem_wdata = buf_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         mem_resp     <= 1'b0;
         mem_rdata    <= '0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         fwd_count    <= '0;
      end else begin
         mem_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_read) begin
                  if (match) begin
                     mem_rdata <= buf_data;
                     fwd_count <= fwd_count + 16'd1;
                     mem_resp  <= 1'b1;
                     state     <= RESP;
                  end else begin
                     pmem_read    <= 1'b1;
                     pmem_address <= mem_address;
                     state        <= READ_MEM;
                  end
               end else if (mem_write) begin
                  if (!buf_valid || match) begin
                     mem_resp <= 1'b1;
                     state    <= RESP;
                  end else begin
                     pmem_write   <= 1'b1;
                     pmem_address <= buf_addr;
                     state        <= DRAIN;
                  end
               end else if (buf_valid) begin
                  pmem_write   <= 1'b1;
                  pmem_address <= buf_addr;
                  state        <= DRAIN;
               end
            end
            READ_MEM: begin
               if (pmem_resp) begin
                  pmem_read <= 1'b0;
                  mem_rdata <= pmem_rdata;
                  mem_resp  <= 1'b1;
                  state     <= RESP;
               end
            end
            DRAIN: begin
               if (pmem_resp) begin
                  pmem_write <= 1'b0;
                  state      <= IDLE;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
